// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// and loads the IF/DE pipeline register, with a one-entry skid buffer for stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eden_hazard,
    input  logic        br_taken_ex,
    input  logic [31:0] br_target_ex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr_de,
    output logic [31:0] pc_de,
    output logic [31:0] pcplus4_de,
    output logic        valid_de
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HELD,
        S_DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_de_reg, pc_de_next;
    logic [31:0] pcplus4_reg, pcplus4_next;
    logic        valid_reg, valid_next;
    logic [31:0] target_aligned;

    assign target_aligned = br_target_ex & ~32'h0000_0003;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC;
            skid_instr_reg <= 32'h0;
            skid_pc_reg    <= 32'h0;
            instr_reg      <= NOP;
            pc_de_reg      <= 32'h0;
            pcplus4_reg    <= 32'h0;
            valid_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            instr_reg      <= instr_next;
            pc_de_reg      <= pc_de_next;
            pcplus4_reg    <= pcplus4_next;
            valid_reg      <= valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        instr_next      = instr_reg;
        pc_de_next      = pc_de_reg;
        pcplus4_next    = pcplus4_reg;
        // A stall freezes the IF/DE register; otherwise it becomes a bubble unless loaded below.
        valid_next      = eden_hazard ? valid_reg : 1'b0;

        case (state_reg)
            S_REQ: state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!eden_hazard) begin
                        instr_next   = imem_rdata;
                        pc_de_next   = pc_reg;
                        pcplus4_next = pc_reg + 32'd4;
                        valid_next   = 1'b1;
                        pc_next      = pc_reg + 32'd4;
                        state_next   = S_REQ;
                    end else begin
                        skid_instr_next = imem_rdata;
                        skid_pc_next    = pc_reg;
                        state_next      = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!eden_hazard) begin
                    instr_next   = skid_instr_reg;
                    pc_de_next   = skid_pc_reg;
                    pcplus4_next = skid_pc_reg + 32'd4;
                    valid_next   = 1'b1;
                    pc_next      = pc_reg + 32'd4;
                    state_next   = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        if (br_taken_ex) begin
            instr_next      = instr_reg;
            pc_de_next      = pc_de_reg;
            pcplus4_next    = pcplus4_reg;
            valid_next      = 1'b0;
            pc_next         = target_aligned;
            skid_instr_next = 32'h0;
            skid_pc_next    = 32'h0;
            // Only a request still in flight needs its response drained in DROP; a response
            // arriving in the redirect cycle (WAIT or DROP) completes it, so fetch restarts.
            case (state_reg)
                S_REQ:   state_next = S_DROP;
                S_WAIT:  state_next = imem_rvalid ? S_REQ : S_DROP;
                S_HELD:  state_next = S_REQ;
                S_DROP:  state_next = imem_rvalid ? S_REQ : S_DROP;
                default: state_next = S_REQ;
            endcase
        end
    end

    assign imem_req   = (state_reg == S_REQ);
    assign imem_addr  = pc_reg;
    assign instr_de   = instr_reg;
    assign pc_de      = pc_de_reg;
    assign pcplus4_de = pcplus4_reg;
    assign valid_de   = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a program-order fetch model feeds a scoreboard queue,
// and a negedge monitor checks every delivered, held or squashed IF/DE value against it.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        eden_hazard;
    logic        br_taken_ex;
    logic [31:0] br_target_ex;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instr_de;
    logic [31:0] pc_de;
    logic [31:0] pcplus4_de;
    logic        valid_de;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .eden_hazard (eden_hazard),
        .br_taken_ex (br_taken_ex),
        .br_target_ex(br_target_ex),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .instr_de    (instr_de),
        .pc_de       (pc_de),
        .pcplus4_de  (pcplus4_de),
        .valid_de    (valid_de)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_push;

    // Memory model state: one outstanding request with a countdown to its response.
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The expected stream is program order from pc, with +4 wrapping modulo 2^32.
    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        next_push = pc;
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endtask

    task automatic cycle(input bit rnd);
        logic [31:0] t;
        @(posedge clk);
        if (br_taken_ex) restart(br_target_ex & ~32'h3);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end
        end else if (rnd && $urandom_range(7) == 0) begin
            imem_rvalid = 1'b1;
        end
        if (imem_req) begin
            pend      = 1'b1;
            cnt       = rnd ? int'($urandom_range(3, 1)) : 1;
            pend_addr = imem_addr;
        end
        eden_hazard = rnd && ($urandom_range(3) == 0);
        br_taken_ex = rnd && ($urandom_range(15) == 0);
        case ($urandom_range(3))
            0: t = 32'hFFFF_FFF0 + $urandom_range(15);
            1: t = 32'h0000_0103;
            default: t = $urandom & 32'h0000_FFFF;
        endcase
        br_target_ex = t;
        refill();
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge clk);
            #3;
        end
        rst = 1'b1;
        #1;
        check("rst_valid_de", {31'b0, valid_de}, 32'h0);
        check("rst_instr_de", instr_de, NOP);
        check("rst_pc_de", pc_de, 32'h0);
        check("rst_pcplus4_de", pcplus4_de, 32'h0);
        check("rst_imem_addr", imem_addr, RPC);
        eden_hazard = 1'b0;
        br_taken_ex = 1'b0;
        imem_rvalid = 1'b0;
        pend        = 1'b0;
        restart(RPC);
        refill();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Cycle 0: a stale response arrives alongside the first request and must be ignored.
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, RPC);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        pend        = 1'b1;
        cnt         = 1;
        pend_addr   = imem_addr;
        cycle(1'b0);
        cycle(1'b0);
        check("c2_valid_de", {31'b0, valid_de}, 32'h1);
        check("c2_pc_de", pc_de, RPC);
        check("c2_pcplus4_wrap", pcplus4_de, 32'h0);
        check("c2_instr_de", instr_de, mem_word(RPC));
        check("c2_req", {31'b0, imem_req}, 32'h1);
        check("c2_addr_wrap", imem_addr, 32'h0);
    endtask

    // Monitor: inputs seen at a negedge are the ones applied at the following posedge.
    bit          hold_prev, br_prev;
    int          idle;
    logic [31:0] s_instr, s_pc, s_p4;
    logic        s_valid;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
            br_prev   = 1'b0;
            idle      = 0;
        end else begin
            if (br_prev) begin
                check("redirect_bubble", {31'b0, valid_de}, 32'h0);
            end else if (hold_prev) begin
                check("hold_valid", {31'b0, valid_de}, {31'b0, s_valid});
                check("hold_instr", instr_de, s_instr);
                check("hold_pc", pc_de, s_pc);
                check("hold_pcplus4", pcplus4_de, s_p4);
            end else if (valid_de) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got delivery pc %h expected none", pc_de);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("deliv_pc", pc_de, e);
                    check("deliv_instr", instr_de, mem_word(e));
                    check("deliv_pcplus4", pcplus4_de, e + 32'd4);
                end
                idle = 0;
            end
            idle++;
            if (idle > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL watchdog: got %0d idle cycles expected at most 300", idle);
                idle = 0;
            end
            s_instr   = instr_de;
            s_pc      = pc_de;
            s_p4      = pcplus4_de;
            s_valid   = valid_de;
            hold_prev = eden_hazard && !br_taken_ex;
            br_prev   = br_taken_ex;
        end
    end

    initial begin
        rst          = 1'b1;
        eden_hazard  = 1'b0;
        br_taken_ex  = 1'b0;
        br_target_ex = 32'h0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        pend         = 1'b0;
        cnt          = 0;
        pend_addr    = 32'h0;
        do_reset(1'b0);
        repeat (3000) cycle(1'b1);
        do_reset(1'b1);
        repeat (3000) cycle(1'b1);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
